// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences a WIDTH-bit up/down counter with
// start/stop/pause control, one-shot or auto-reload operation.
//
// Ports:
//   clk         rising-edge clock
//   res         synchronous active-high reset
//   start       begin a sequence (accepted only in IDLE)
//   stop        abort the sequence, return to IDLE
//   pause       level, freezes the count (RUN <-> HOLD)
//   mode_down   0 = count up 0..limit, 1 = down limit..0
//   auto_reload 1 = reload at terminal and keep running
//   limit       terminal (up) / initial (down) value
//   count       current count
//   cnt_en      count steps by one on the next edge
//   tc          terminal count reached this cycle
//   busy        state is RUN or HOLD
//   done        one-cycle strobe on one-shot completion
//   state       IDLE=0, RUN=1, HOLD=2, DONE=3
//   wraps       (only with CNT_WRAP_COUNT_EN) saturating count of
//               reload events since the last accepted start
//
// Optional feature macro: CNT_WRAP_COUNT_EN
module counter_sequencer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode_down,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             cnt_en,
   output logic             tc,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
`ifdef CNT_WRAP_COUNT_EN
   ,
   output logic [7:0]       wraps
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             dir_q, dir_d;
   logic             rel_q, rel_d;

   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] init;
   logic             at_term;
   logic             accept;

   assign term    = dir_q ? '0 : lim_q;
   assign init    = dir_q ? lim_q : '0;
   assign at_term = (count_q == term);
   assign accept  = (state_q == S_IDLE) && start;

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= S_IDLE;
         count_q <= '0;
         lim_q   <= '0;
         dir_q   <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lim_q   <= lim_d;
         dir_q   <= dir_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lim_d   = lim_q;
      dir_d   = dir_q;
      rel_d   = rel_q;
      cnt_en  = 1'b0;
      tc      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               lim_d   = limit;
               dir_d   = mode_down;
               rel_d   = auto_reload;
               count_d = mode_down ? limit : '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (pause) begin
               state_d = S_HOLD;
            end else if (at_term) begin
               tc = 1'b1;
               if (rel_q) begin
                  count_d = init;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_en  = 1'b1;
               count_d = dir_q ? count_q - ONE
                               : count_q + ONE;
            end
         end
         S_HOLD: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (!pause) begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign count = count_q;
   assign state = state_q;
   assign busy  = (state_q == S_RUN) || (state_q == S_HOLD);
   assign done  = (state_q == S_DONE);

`ifdef CNT_WRAP_COUNT_EN
   logic [7:0] wraps_q, wraps_d;

   // tc with rel_q set is exactly a reload event
   always_comb begin
      wraps_d = wraps_q;
      if (accept) begin
         wraps_d = '0;
      end else if (tc && rel_q && (wraps_q != 8'hFF)) begin
         wraps_d = wraps_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wraps_q <= '0;
      end else begin
         wraps_q <= wraps_d;
      end
   end

   assign wraps = wraps_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed + random stimulus for
// counter_sequencer, checked against a behavioural model.
module tb_counter_sequencer;

   logic       clk;
   logic       res;
   logic       start;
   logic       stop;
   logic       pause;
   logic       mode_down;
   logic       auto_reload;
   logic [2:0] limit;
   logic [2:0] count;
   logic       cnt_en;
   logic       tc;
   logic       busy;
   logic       done;
   logic [1:0] state;
`ifdef CNT_WRAP_COUNT_EN
   logic [7:0] wraps;
`endif

   int vectors;
   int miscompares;

   // reference model
   int m_st;
   int m_cnt;
   int m_lim;
   int m_dir;
   int m_rel;
   int m_wraps;

   counter_sequencer #(.WIDTH(3)) dut (
      .clk         (clk),
      .res         (res),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .mode_down   (mode_down),
      .auto_reload (auto_reload),
      .limit       (limit),
      .count       (count),
      .cnt_en      (cnt_en),
      .tc          (tc),
      .busy        (busy),
      .done        (done),
      .state       (state)
`ifdef CNT_WRAP_COUNT_EN
      ,
      .wraps       (wraps)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h",
                  tag, got, exp);
         $error("miscompare on %s", tag);
      end
   endtask

   // one clock: check outputs mid-cycle, then advance the model
   task automatic cycle();
      int term;
      int e_tc;
      int e_en;
      #3;
      term = m_dir ? 0 : m_lim;
      e_tc = (m_st == 1 && m_cnt == term && !stop && !pause);
      e_en = (m_st == 1 && m_cnt != term && !stop && !pause);
      chk("count",  8'(count),  8'(m_cnt));
      chk("state",  8'(state),  8'(m_st));
      chk("busy",   8'(busy),   8'(m_st == 1 || m_st == 2));
      chk("done",   8'(done),   8'(m_st == 3));
      chk("tc",     8'(tc),     8'(e_tc));
      chk("cnt_en", 8'(cnt_en), 8'(e_en));
`ifdef CNT_WRAP_COUNT_EN
      chk("wraps",  wraps,      8'(m_wraps));
`endif
      @(posedge clk);
      if (res) begin
         m_st = 0; m_cnt = 0; m_lim = 0;
         m_dir = 0; m_rel = 0; m_wraps = 0;
      end else begin
         case (m_st)
            0: if (start) begin
               m_lim = limit; m_dir = mode_down;
               m_rel = auto_reload; m_wraps = 0;
               m_cnt = mode_down ? int'(limit) : 0;
               m_st = 1;
            end
            1: if (stop) m_st = 0;
               else if (pause) m_st = 2;
               else if (e_tc) begin
                  if (m_rel) begin
                     m_cnt = m_dir ? m_lim : 0;
                     if (m_wraps < 255) m_wraps++;
                  end else m_st = 3;
               end else m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
            2: if (stop) m_st = 0;
               else if (!pause) m_st = 1;
            default: m_st = 0;
         endcase
      end
      #1;
   endtask

   task automatic drv(input logic r, input logic s,
                      input logic sp, input logic p,
                      input logic md, input logic ar,
                      input logic [2:0] l);
      res = r; start = s; stop = sp; pause = p;
      mode_down = md; auto_reload = ar; limit = l;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drv(0, 0, 0, 0, 0, 0, 3'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      m_st = 0; m_cnt = 0; m_lim = 0;
      m_dir = 0; m_rel = 0; m_wraps = 0;
      res = 1; start = 1; stop = 0; pause = 0;
      mode_down = 1; auto_reload = 1; limit = 3'd6;
      @(posedge clk); #1;
      // reset with busy inputs
      drv(1, 1, 1, 1, 1, 1, 3'd6);
      drv(1, 0, 0, 0, 0, 0, 3'd0);
      idle(1);
      // up one-shot, limit 5
      drv(0, 1, 0, 0, 0, 0, 3'd5);
      idle(9);
      // down auto-reload, limit 2, then stop
      drv(0, 1, 0, 0, 1, 1, 3'd2);
      idle(8);
      drv(0, 0, 1, 0, 0, 0, 3'd0);
      idle(2);
      // pause at 3, resume to completion
      drv(0, 1, 0, 0, 0, 0, 3'd7);
      idle(3);
      for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0, 0, 3'd0);
      idle(8);
      // stop during HOLD
      drv(0, 1, 0, 0, 0, 0, 3'd7);
      idle(3);
      drv(0, 0, 0, 1, 0, 0, 3'd0);
      drv(0, 0, 0, 1, 0, 0, 3'd0);
      drv(0, 0, 1, 1, 0, 0, 3'd0);
      idle(2);
      // limit 0 one-shot and auto-reload
      drv(0, 1, 0, 0, 0, 0, 3'd0);
      idle(3);
      drv(0, 1, 0, 0, 0, 1, 3'd0);
      idle(4);
      drv(0, 0, 1, 0, 0, 0, 3'd0);
      // start during RUN ignored
      drv(0, 1, 0, 0, 0, 0, 3'd6);
      idle(2);
      drv(0, 1, 0, 0, 1, 1, 3'd2);
      idle(7);
      // reset mid-run at count 4
      drv(0, 1, 0, 0, 0, 0, 3'd7);
      idle(4);
      drv(1, 0, 0, 0, 0, 0, 3'd0);
      idle(3);
      // random phase
      for (int i = 0; i < 1500; i++) begin
         drv(($urandom % 64) == 0,
             ($urandom % 4) == 0,
             ($urandom % 16) == 0,
             ($urandom % 5) == 0,
             1'($urandom),
             1'($urandom),
             3'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control block that sequences a WIDTH-bit synchronous counter datapath.
- Configuration is latched on a start pulse: modulus limit, direction (up/down) and one-shot vs auto-reload.
- Run, pause and stop are controlled through dedicated inputs.
- Outputs: current count, terminal-count (tc) strobe and completion (done) strobe.
- Used wherever the design needs a programmable count/timing sequence instead of a free-running counter.

Parameters:
WIDTH, 3, counter width in bits; limit and count are WIDTH bits.

Ports:
clk  input  1  clock, rising edge
res  input  1  reset, synchronous, active-high
start  input  1  begin a sequence; sampled only in IDLE
stop  input  1  abort the sequence; return to IDLE
pause  input  1  level; freeze the count while high (RUN/HOLD)
mode_down  input  1  0 = count up 0..limit; 1 = count down limit..0; latched at start
auto_reload  input  1  1 = reload at terminal and continue; latched at start
limit  input  WIDTH  terminal (up) or initial (down) value; latched at start
count  output  WIDTH  current count value
cnt_en  output  1  high in cycles where count steps by ±1 on the next edge
tc  output  1  terminal count reached this cycle
busy  output  1  state is RUN or HOLD
done  output  1  one-cycle strobe on one-shot completion
state  output  2  IDLE=0, RUN=1, HOLD=2, DONE=3

Behaviour:
Clocking and reset:
- All registers update on the rising edge of clk.
- res=1 at an edge forces: state=IDLE, count=0, latched config=0.
- res has absolute priority, including mid-sequence.
- All outputs read 0 after reset.

Terminal and initial values:
- term = 0 if dir_r else lim_r.
- init = lim_r if dir_r else 0.
- tc = (state==RUN) & (count==term) & ~stop & ~pause. This output is combinational from registers and inputs.

IDLE:
- count holds its last value.
- start=1: latch lim_r<=limit, dir_r<=mode_down, rel_r<=auto_reload; count<=limit if mode_down else 0; go to RUN.
- No action otherwise.

RUN (priority order, highest first):
- stop: go to IDLE; count held.
- pause: go to HOLD; count held.
- count==term: tc=1. If rel_r, count<=init and stay in RUN. Otherwise go to DONE with count held.
- Otherwise: count<=count+1 (up) or count-1 (down); cnt_en=1.

HOLD:
- stop: go to IDLE.
- pause=0: go to RUN. Counting resumes on the following edge.
- Count is held throughout.

DONE:
- done=1 for exactly this cycle.
- Next edge: go to IDLE.
- start and stop are ignored.

Boundary conditions:
- start outside IDLE is ignored; latched config cannot change mid-sequence.
- limit=0: tc is asserted in the first RUN cycle. One-shot goes to DONE; auto-reload asserts tc every cycle.
- Count never wraps past limit or below 0.
- Latency from start to the first count step: start edge loads init; first step on the next edge.
- Sequence length: one-shot lasts limit+1 RUN cycles before DONE.
- Auto-reload period: tc every limit+1 RUN cycles.

Optional Feature:
Macro: CNT_WRAP_COUNT_EN
- Defined: adds output port wraps[7:0], counting tc events while rel_r=1.
  - Saturates at 255.
  - Cleared to 0 on res and on an accepted start.
  - Holds its value in IDLE.
- Undefined: no wraps port and no associated logic.

Test Plan:
1. Reset: res=1 for 2 cycles with any inputs -> count=0, state=0, busy=0, tc=0, done=0, cnt_en=0.
2. Up one-shot: start=1, limit=5, mode_down=0, auto_reload=0 for one cycle.
   - count steps 0,1,2,3,4,5 on successive edges; tc=1 only while count=5.
   - Next cycle state=DONE with done=1; then IDLE with count=5.
3. Down auto-reload: limit=2, mode_down=1, auto_reload=1.
   - count sequence 2,1,0,2,1,0,2...; tc=1 at each 0.
   - stop=1 mid-run -> IDLE next cycle with count held; with CNT_WRAP_COUNT_EN, wraps increments by 1 per tc.
4. Pause/resume: up, limit=7, pause=1 when count=3 for 4 cycles.
   - state=HOLD, count stays 3, cnt_en=0.
   - After pause drops: RUN, then 4,5,6,7, then done.
   - stop during HOLD -> IDLE, count=3.
5. Edge cases:
   - limit=0 up one-shot: tc in first RUN cycle, done next cycle.
   - start pulsed during RUN with a new limit: ignored; the original sequence completes unchanged.
6. Reset mid-run: res=1 while count=4 in RUN -> next cycle state=IDLE, count=0, busy=0, and no done strobe is produced.
